// File: rtl/cpu_board_io_pkg.sv
// cpu_board_pkg: shared constants for the CPU board I/O stage.
//   - display mode codes selected by sw_sel
//   - blank segment pattern
//   - hex digit to active-low seven-segment table and decode function
// Segment byte layout: bit 7 = dp, bits 6:0 = {g,f,e,d,c,b,a}, all active-low.
package cpu_board_pkg;

   localparam logic [1:0] MODE_PC  = 2'd0;
   localparam logic [1:0] MODE_RS  = 2'd1;
   localparam logic [1:0] MODE_RT  = 2'd2;
   localparam logic [1:0] MODE_ALU = 2'd3;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // dp is kept off (bit 7 high) in every entry
   localparam logic [7:0] HEX_SEG [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
      return HEX_SEG[nib];
   endfunction

endpackage

// File: rtl/cpu_board_io_step_debouncer.sv
// step_debouncer: synchronizes and debounces the single-step push-button.
// Ports:
//   CLK     - board clock, rising edge
//   Reset   - asynchronous active-low reset
//   btn_in  - raw asynchronous button, high = pressed
//   btn_out - debounced level; changes 2+DEBOUNCE_CYCLES edges after a stable input change
// Parameter DEBOUNCE_CYCLES (>= 2): consecutive mismatching samples needed to flip the level.
module step_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic CLK,
   input  logic Reset,
   input  logic btn_in,
   output logic btn_out
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

   logic            sync1;
   logic            s_btn;
   logic            deb;
   logic [CntW-1:0] cnt;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         sync1 <= 1'b0;
         s_btn <= 1'b0;
         deb   <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= btn_in;
         s_btn <= sync1;
         if (s_btn == deb) begin
            // any agreement, however brief, restarts the stability count
            cnt <= '0;
         end else if (cnt == CntW'(DEBOUNCE_CYCLES - 1)) begin
            deb <= s_btn;
            cnt <= '0;
         end else begin
            cnt <= cnt + CntW'(1);
         end
      end
   end

   assign btn_out = deb;

endmodule

// File: rtl/cpu_board_io.sv
// cpu_board_io: board-side companion to the multicycle CPU.
//   - debounces btn_step into the CPU step clock cpu_clk
//   - scans a selected pair of debug bytes onto a 4-digit active-low seven-segment display
// Ports:
//   CLK, Reset (async active-low)
//   btn_step              raw step button
//   sw_sel[1:0]           display mode: 0 PC cur/next, 1 rs addr/data, 2 rt addr/data,
//                         3 ALU result / DB bus
//   pc_cur, pc_next, rs_addr, rs_data, rt_addr, rt_data, alu_result, db_data  CPU debug taps
//   cpu_clk               debounced step clock
//   an[3:0]               digit enables, active-low, an[3] leftmost
//   seg[7:0]              segments, active-low, seg[7] = dp
// Optional: define CPU_BOARD_STEP_COUNT_EN to add step_count[15:0], a count of step
//   presses that replaces ALU/DB on mode 3.
module cpu_board_io
   import cpu_board_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned SCAN_DIV        = 100000
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        btn_step,
   input  logic [1:0]  sw_sel,
   input  logic [31:0] pc_cur,
   input  logic [31:0] pc_next,
   input  logic [4:0]  rs_addr,
   input  logic [31:0] rs_data,
   input  logic [4:0]  rt_addr,
   input  logic [31:0] rt_data,
   input  logic [31:0] alu_result,
   input  logic [31:0] db_data,
`ifdef CPU_BOARD_STEP_COUNT_EN
   output logic [15:0] step_count,
`endif
   output logic        cpu_clk,
   output logic [3:0]  an,
   output logic [7:0]  seg
);

   localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [ScanW-1:0] scan_cnt;
   logic [1:0]       digit_idx;
   logic             scan_tick;
   logic [7:0]       first_byte;
   logic [7:0]       second_byte;
   logic [3:0]       nib;
   logic [3:0]       an_d;
   logic [7:0]       seg_d;

   step_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_step_debouncer (
      .CLK    (CLK),
      .Reset  (Reset),
      .btn_in (btn_step),
      .btn_out(cpu_clk)
   );

`ifdef CPU_BOARD_STEP_COUNT_EN
   logic        deb_prev;
   logic [15:0] step_q;

   // rising edge of the debounced level is seen one edge after deb sets
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         deb_prev <= 1'b0;
         step_q   <= 16'h0000;
      end else begin
         deb_prev <= cpu_clk;
         if (cpu_clk && !deb_prev) begin
            step_q <= step_q + 16'd1;
         end
      end
   end

   assign step_count = step_q;
`endif

   // byte-pair selection for the current mode
   always_comb begin
      first_byte  = 8'h00;
      second_byte = 8'h00;
      unique case (sw_sel)
         MODE_PC: begin
            first_byte  = pc_cur[7:0];
            second_byte = pc_next[7:0];
         end
         MODE_RS: begin
            first_byte  = {3'b000, rs_addr};
            second_byte = rs_data[7:0];
         end
         MODE_RT: begin
            first_byte  = {3'b000, rt_addr};
            second_byte = rt_data[7:0];
         end
         MODE_ALU: begin
`ifdef CPU_BOARD_STEP_COUNT_EN
            first_byte  = step_q[15:8];
            second_byte = step_q[7:0];
`else
            first_byte  = alu_result[7:0];
            second_byte = db_data[7:0];
`endif
         end
         default: begin
            first_byte  = 8'h00;
            second_byte = 8'h00;
         end
      endcase
   end

   // digit 0 is rightmost: low nibble of the second byte
   always_comb begin
      an_d = 4'b1111;
      nib  = 4'h0;
      unique case (digit_idx)
         2'd0: begin
            an_d = 4'b1110;
            nib  = second_byte[3:0];
         end
         2'd1: begin
            an_d = 4'b1101;
            nib  = second_byte[7:4];
         end
         2'd2: begin
            an_d = 4'b1011;
            nib  = first_byte[3:0];
         end
         2'd3: begin
            an_d = 4'b0111;
            nib  = first_byte[7:4];
         end
         default: begin
            an_d = 4'b1111;
            nib  = 4'h0;
         end
      endcase
      seg_d = hex_to_seg(nib);
   end

   assign scan_tick = (scan_cnt == ScanW'(SCAN_DIV - 1));

   // an/seg are re-registered every cycle from the index held before this edge,
   // so each digit stays lit for exactly SCAN_DIV cycles
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         scan_cnt  <= '0;
         digit_idx <= 2'd0;
         an        <= 4'b1111;
         seg       <= SEG_BLANK;
      end else begin
         if (scan_tick) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + ScanW'(1);
         end
         an  <= an_d;
         seg <= seg_d;
      end
   end

   // only the low bytes of the data taps reach the display
   logic unused_inputs;
   assign unused_inputs = ^{pc_cur[31:8], pc_next[31:8], rs_data[31:8], rt_data[31:8],
                            alu_result, db_data};

endmodule

// File: tb/tb_cpu_board_io.sv
// Scoreboard bench for cpu_board_io with DEBOUNCE_CYCLES=4, SCAN_DIV=3.
// Stimulus runs at negedges and queues the expected outputs for the following
// posedge; a monitor samples 1 time unit after each posedge and compares.
module tb_cpu_board_io;

   logic        CLK;
   logic        Reset;
   logic        btn_step;
   logic [1:0]  sw_sel;
   logic [31:0] pc_cur;
   logic [31:0] pc_next;
   logic [4:0]  rs_addr;
   logic [31:0] rs_data;
   logic [4:0]  rt_addr;
   logic [31:0] rt_data;
   logic [31:0] alu_result;
   logic [31:0] db_data;
   logic        cpu_clk;
   logic [3:0]  an;
   logic [7:0]  seg;
`ifdef CPU_BOARD_STEP_COUNT_EN
   logic [15:0] step_count;
`endif

   cpu_board_io #(
      .DEBOUNCE_CYCLES(4),
      .SCAN_DIV       (3)
   ) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .btn_step  (btn_step),
      .sw_sel    (sw_sel),
      .pc_cur    (pc_cur),
      .pc_next   (pc_next),
      .rs_addr   (rs_addr),
      .rs_data   (rs_data),
      .rt_addr   (rt_addr),
      .rt_data   (rt_data),
      .alu_result(alu_result),
      .db_data   (db_data),
`ifdef CPU_BOARD_STEP_COUNT_EN
      .step_count(step_count),
`endif
      .cpu_clk   (cpu_clk),
      .an        (an),
      .seg       (seg)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic        eclk;
      logic [3:0]  ean;
      logic [7:0]  eseg;
      bit          chk_step;
      logic [15:0] estep;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_k = 0;

   logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   // expected segment byte for digit index 0..3 of the current mode/data
   logic [7:0] dig [4];

   // queue the expectation for the coming posedge, then move to the next negedge
   task automatic tick(input string nm, input logic eclk, input bit chk_step,
                       input logic [15:0] estep);
      exp_t e;
      int   idx;
      e.name     = nm;
      e.eclk     = eclk;
      e.chk_step = chk_step;
      e.estep    = estep;
      if (!Reset) begin
         edge_k = 0;
         e.ean  = 4'b1111;
         e.eseg = 8'hFF;
      end else begin
         edge_k = edge_k + 1;
         idx    = ((edge_k - 1) / 3) % 4;
         e.ean  = an_tab[idx];
         e.eseg = dig[idx];
      end
      q.push_back(e);
      @(negedge CLK);
   endtask

   // button level held for n cycles; cpu_clk follows 6 edges after the change
   task automatic hold_btn(input string nm, input logic lvl, input logic prev, input int n);
      btn_step = lvl;
      for (int j = 1; j <= n; j++) begin
         tick(nm, (j >= 6) ? lvl : prev, 1'b0, 16'h0);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks = checks + 1;
            if (cpu_clk !== e.eclk) begin
               errors = errors + 1;
               $display("FAIL %s cpu_clk: got %b expected %b (t=%0t)", e.name, cpu_clk,
                        e.eclk, $time);
            end
            checks = checks + 1;
            if (an !== e.ean) begin
               errors = errors + 1;
               $display("FAIL %s an: got %b expected %b (t=%0t)", e.name, an, e.ean, $time);
            end
            checks = checks + 1;
            if (seg !== e.eseg) begin
               errors = errors + 1;
               $display("FAIL %s seg: got %h expected %h (t=%0t)", e.name, seg, e.eseg,
                        $time);
            end
`ifdef CPU_BOARD_STEP_COUNT_EN
            if (e.chk_step) begin
               checks = checks + 1;
               if (step_count !== e.estep) begin
                  errors = errors + 1;
                  $display("FAIL %s step_count: got %h expected %h", e.name, step_count,
                           e.estep);
               end
            end
`endif
         end
      end
   end

   initial begin : stim
      Reset      = 1'b0;
      btn_step   = 1'b0;
      sw_sel     = 2'd2;
      pc_cur     = 32'hDEADBEEF;
      pc_next    = 32'h12345678;
      rs_addr    = 5'd7;
      rs_data    = 32'hCAFEF00D;
      rt_addr    = 5'd9;
      rt_data    = 32'h0BADC0DE;
      alu_result = 32'h55AA55AA;
      db_data    = 32'hA5A5A5A5;
      dig        = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

      // reset with arbitrary inputs
      repeat (3) tick("reset", 1'b0, 1'b0, 16'h0);

      // release; PC mode "14" / "18"
      Reset   = 1'b1;
      sw_sel  = 2'd0;
      pc_cur  = 32'h00000014;
      pc_next = 32'h00000018;
      dig     = '{8'h80, 8'hF9, 8'h99, 8'hF9};
      repeat (13) tick("scan_pc", 1'b0, 1'b0, 16'h0);

      // clean press and release
      hold_btn("press", 1'b1, 1'b0, 10);
      hold_btn("release", 1'b0, 1'b1, 10);

      // bounce: 3 high, 2 low, never long enough
      for (int r = 0; r < 4; r++) begin
         btn_step = 1'b1;
         repeat (3) tick("bounce", 1'b0, 1'b0, 16'h0);
         btn_step = 1'b0;
         repeat (2) tick("bounce", 1'b0, 1'b0, 16'h0);
      end
      repeat (8) tick("settle", 1'b0, 1'b0, 16'h0);

      // rs mode: "1F" / "AF"
      sw_sel  = 2'd1;
      rs_addr = 5'd31;
      rs_data = 32'h123456AF;
      dig     = '{8'h8E, 8'h88, 8'h8E, 8'hF9};
      repeat (5) tick("mode_rs", 1'b0, 1'b0, 16'h0);

      // mode 3 mid-scan
      sw_sel     = 2'd3;
      alu_result = 32'hABCD003C;
      db_data    = 32'h000000E1;
`ifdef CPU_BOARD_STEP_COUNT_EN
      dig = '{8'hF9, 8'hC0, 8'hC0, 8'hC0};
`else
      dig = '{8'hF9, 8'h86, 8'hC6, 8'hB0};
`endif
      repeat (7) tick("mode_alu", 1'b0, 1'b0, 16'h0);

      // rt mode: "02" / "5B"
      sw_sel  = 2'd2;
      rt_addr = 5'd2;
      rt_data = 32'hFFFFFF5B;
      dig     = '{8'h83, 8'h92, 8'hA4, 8'hC0};
      repeat (6) tick("mode_rt", 1'b0, 1'b0, 16'h0);

      sw_sel = 2'd0;
      dig    = '{8'h80, 8'hF9, 8'h99, 8'hF9};
`ifdef CPU_BOARD_STEP_COUNT_EN
      hold_btn("press2", 1'b1, 1'b0, 10);
      hold_btn("release2", 1'b0, 1'b1, 10);
      hold_btn("press3", 1'b1, 1'b0, 10);
      hold_btn("release3", 1'b0, 1'b1, 10);
      sw_sel = 2'd3;
      dig    = '{8'hB0, 8'hC0, 8'hC0, 8'hC0};
      repeat (6) tick("step_count", 1'b0, 1'b1, 16'h0003);
      sw_sel = 2'd0;
      dig    = '{8'h80, 8'hF9, 8'h99, 8'hF9};
`endif

      // reset while the button is held counts as a new press
      hold_btn("hold", 1'b1, 1'b0, 8);
      Reset = 1'b0;
      repeat (2) tick("reset_mid", 1'b0, 1'b0, 16'h0);
      Reset = 1'b1;
      hold_btn("repress", 1'b1, 1'b0, 10);
      hold_btn("rerelease", 1'b0, 1'b1, 10);

      @(posedge CLK);
      #2;
      checks = checks + 1;
      if (q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
